// File: rtl/dbscan_pkg.sv
// rtl/dbscan_pkg.sv - shared widths, label constants and sequencer state encoding
package dbscan_pkg;
   localparam int IW      = 4;
   localparam int LABEL_W = 4;
   localparam int DIST_W  = 18;

   localparam logic [LABEL_W-1:0] NOISE = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CORE,
      S_CDRAIN,
      S_EXPAND,
      S_EDRAIN,
      S_READ
   } state_t;
endpackage

// File: rtl/dbscan_if.sv
// rtl/dbscan_if.sv - pair/distance channel and label readout channel of the sequencer
interface dbscan_if
   import dbscan_pkg::*;
#(
   parameter int IW = 4
);
   logic               pair_valid;
   logic [IW-1:0]      pair_i;
   logic [IW-1:0]      pair_j;
   logic               dist_valid;
   logic [DIST_W-1:0]  dist2;
   logic               rd_valid;
   logic               rd_ready;
   logic [IW-1:0]      rd_idx;
   logic [LABEL_W-1:0] rd_label;
   logic               rd_core;

   modport master (
      output pair_valid, pair_i, pair_j,
      input  dist_valid, dist2,
      output rd_valid, rd_idx, rd_label, rd_core,
      input  rd_ready
   );

   modport slave (
      input  pair_valid, pair_i, pair_j,
      output dist_valid, dist2,
      input  rd_valid, rd_idx, rd_label, rd_core,
      output rd_ready
   );
endinterface

// File: rtl/dbscan_idx_pipe.sv
// rtl/dbscan_idx_pipe.sv - DLAT-deep (valid,i,j) tag line matching the external distance pipe
module dbscan_idx_pipe
   import dbscan_pkg::*;
#(
   parameter int DLAT = 2,
   parameter int IW   = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [IW-1:0] in_i,
   input  logic [IW-1:0] in_j,
   output logic          out_valid,
   output logic [IW-1:0] out_i,
   output logic [IW-1:0] out_j
);
   logic [DLAT-1:0] v;
   logic [IW-1:0]   si [DLAT];
   logic [IW-1:0]   sj [DLAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int k = 0; k < DLAT; k++) begin
            si[k] <= '0;
            sj[k] <= '0;
         end
      end else begin
         v[0]  <= in_valid;
         si[0] <= in_i;
         sj[0] <= in_j;
         for (int k = 1; k < DLAT; k++) begin
            v[k]  <= v[k-1];
            si[k] <= si[k-1];
            sj[k] <= sj[k-1];
         end
      end
   end

   assign out_valid = v[DLAT-1];
   assign out_i     = si[DLAT-1];
   assign out_j     = sj[DLAT-1];
endmodule

// File: rtl/dbscan_seq.sv
// rtl/dbscan_seq.sv - all-pairs DBSCAN labelling sequencer with label readout
// DBSCAN_EARLY_EXIT_EN: also leave the expand loop after a pass that changed nothing
module dbscan_seq
   import dbscan_pkg::*;
#(
   parameter int N        = 16,
   parameter int IW       = 4,
   parameter int DLAT     = 2,
   parameter int MAX_ITER = 6
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DIST_W-1:0]  cfg_eps2,
   input  logic [3:0]         cfg_minpts,
   dbscan_if.master           bus,
   output logic [LABEL_W-1:0] n_clusters,
   output logic [7:0]         iter_cnt,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam logic [IW-1:0] LAST      = IW'(N - 1);
   localparam logic [7:0]    DRAIN_END = 8'(DLAT - 1);
   localparam logic [7:0]    ITER_MAX  = 8'(MAX_ITER);

   state_t              state, state_n;
   logic [DIST_W-1:0]   eps2;
   logic [3:0]          minpts;
   logic [IW-1:0]       pi, pj, rd_idx;
   logic [7:0]          dcnt, iter_n;
   logic [3:0]          cnt, cnt_sum;
   logic [LABEL_W-1:0]  next_label, li;
   logic                changed, changed_now;
   logic [LABEL_W-1:0]  label [N];
   logic [N-1:0]        core;
   logic                tag_valid;
   logic [IW-1:0]       tag_i, tag_j;
   logic                issuing, last_pair, drain_end, nb, exp_hit, alloc, relabel;
   logic                exit_now, rd_fire, core_phase;

   dbscan_idx_pipe #(.DLAT(DLAT), .IW(IW)) u_pipe (
      .clk(clk), .rst(rst),
      .in_valid(issuing), .in_i(pi), .in_j(pj),
      .out_valid(tag_valid), .out_i(tag_i), .out_j(tag_j)
   );

   // Results are matched to the tag that emerges this cycle, never to the issued pair.
   always_comb begin
      issuing     = (state == S_CORE) || (state == S_EXPAND);
      core_phase  = (state == S_CORE) || (state == S_CDRAIN);
      last_pair   = issuing && (pi == LAST) && (pj == LAST);
      drain_end   = ((state == S_CDRAIN) || (state == S_EDRAIN)) && (dcnt == DRAIN_END);
      nb          = tag_valid && bus.dist_valid && (tag_i != tag_j) && (bus.dist2 < eps2);
      cnt_sum     = (nb && (cnt != 4'hF)) ? cnt + 4'd1 : cnt;
      exp_hit     = nb && ((state == S_EXPAND) || (state == S_EDRAIN)) && core[tag_i];
      alloc       = exp_hit && (label[tag_i] == NOISE);
      li          = alloc ? next_label : label[tag_i];
      relabel     = exp_hit && ((label[tag_j] == NOISE) || (label[tag_j] > li));
      changed_now = changed | alloc | relabel;
      iter_n      = iter_cnt + 8'd1;
`ifdef DBSCAN_EARLY_EXIT_EN
      exit_now    = !changed_now || (iter_n == ITER_MAX);
`else
      exit_now    = (iter_n == ITER_MAX);
`endif
      rd_fire     = (state == S_READ) && bus.rd_ready;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (start)     state_n = S_CORE;
         S_CORE:   if (last_pair) state_n = S_CDRAIN;
         S_CDRAIN: if (drain_end) state_n = S_EXPAND;
         S_EXPAND: if (last_pair) state_n = S_EDRAIN;
         S_EDRAIN: if (drain_end) state_n = exit_now ? S_READ : S_EXPAND;
         S_READ:   if (rd_fire && (rd_idx == LAST)) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eps2       <= '0;
         minpts     <= '0;
         pi         <= '0;
         pj         <= '0;
         rd_idx     <= '0;
         dcnt       <= '0;
         cnt        <= '0;
         next_label <= LABEL_W'(1);
         changed    <= 1'b0;
         core       <= '0;
         iter_cnt   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         for (int k = 0; k < N; k++) label[k] <= NOISE;
      end else begin
         done    <= 1'b0;
         changed <= changed_now;
         if (tag_valid != bus.dist_valid) err <= 1'b1;
         if (issuing) begin
            pj <= pj + 1'b1;
            if (pj == LAST) pi <= pi + 1'b1;
         end
         if ((state == S_CDRAIN) || (state == S_EDRAIN)) dcnt <= drain_end ? 8'd0 : dcnt + 8'd1;
         if (tag_valid && core_phase) begin
            if (tag_j == LAST) begin
               core[tag_i] <= (cnt_sum >= minpts);
               cnt         <= '0;
            end else begin
               cnt <= cnt_sum;
            end
         end
         if (alloc) begin
            label[tag_i] <= next_label;
            if (next_label != 4'hF) next_label <= next_label + 1'b1;
         end
         if (relabel) label[tag_j] <= li;
         if ((state == S_EDRAIN) && drain_end) begin
            iter_cnt <= iter_n;
            changed  <= 1'b0;
         end
         if (rd_fire) begin
            if (rd_idx == LAST) begin
               rd_idx <= '0;
               done   <= 1'b1;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end
         if ((state == S_IDLE) && start) begin
            eps2       <= cfg_eps2;
            minpts     <= cfg_minpts;
            core       <= '0;
            next_label <= LABEL_W'(1);
            iter_cnt   <= '0;
            changed    <= 1'b0;
            cnt        <= '0;
            pi         <= '0;
            pj         <= '0;
            rd_idx     <= '0;
            dcnt       <= '0;
            for (int k = 0; k < N; k++) label[k] <= NOISE;
         end
      end
   end

   assign bus.pair_valid = issuing;
   assign bus.pair_i     = pi;
   assign bus.pair_j     = pj;
   assign bus.rd_valid   = (state == S_READ);
   assign bus.rd_idx     = rd_idx;
   assign bus.rd_label   = label[rd_idx];
   assign bus.rd_core    = core[rd_idx];
   assign n_clusters     = next_label - 1'b1;
   assign busy           = (state != S_IDLE);
endmodule

// File: tb/tb_dbscan_seq.sv
// tb/tb_dbscan_seq.sv - self-checking bench: directed table, random point sets, stall and reset sequences
module tb_dbscan_seq;
   import dbscan_pkg::*;

   localparam int N        = 16;
   localparam int DLAT     = 2;
   localparam int MAX_ITER = 6;
`ifdef DBSCAN_EARLY_EXIT_EN
   localparam logic [7:0] EXP_IT = 8'd2;
`else
   localparam logic [7:0] EXP_IT = 8'(MAX_ITER);
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [17:0] cfg_eps2 = '0;
   logic [3:0]  cfg_minpts = '0;
   logic [3:0]  n_clusters;
   logic [7:0]  iter_cnt;
   logic        busy, done, err;

   dbscan_if #(.IW(IW)) bus ();

   dbscan_seq #(.N(N), .IW(IW), .DLAT(DLAT), .MAX_ITER(MAX_ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_eps2(cfg_eps2), .cfg_minpts(cfg_minpts),
      .bus(bus), .n_clusters(n_clusters), .iter_cnt(iter_cnt),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Distance pipe: a lookup into dmat delayed by DLAT, with one optional dropped strobe.
   logic [17:0] dmat [N][N];
   int          drop_ord = -1;
   logic        tv [DLAT];
   int          ti [DLAT];
   int          tj [DLAT];
   int          ord;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DLAT; k++) begin
            tv[k] <= 1'b0;
            ti[k] <= 0;
            tj[k] <= 0;
         end
         ord <= 0;
      end else begin
         tv[0] <= bus.pair_valid;
         ti[0] <= int'(bus.pair_i);
         tj[0] <= int'(bus.pair_j);
         for (int k = 1; k < DLAT; k++) begin
            tv[k] <= tv[k-1];
            ti[k] <= ti[k-1];
            tj[k] <= tj[k-1];
         end
         if (start) ord <= 0;
         else if (tv[DLAT-1]) ord <= ord + 1;
      end
   end

   always_comb begin
      bus.dist_valid = tv[DLAT-1] && (ord != drop_ord);
      bus.dist2      = dmat[ti[DLAT-1]][tj[DLAT-1]];
   end

   task automatic set_far();
      for (int a = 0; a < N; a++)
         for (int b = 0; b < N; b++)
            dmat[a][b] = (a == b) ? 18'd0 : 18'd1000;
   endtask

   task automatic link(input int a, input int b);
      dmat[a][b] = 18'd100;
      dmat[b][a] = 18'd100;
   endtask

   task automatic setup_scen(input int scen);
      set_far();
      if (scen == 2) begin
         for (int k = 0; k < 4; k++) link(k, k + 1);
      end else begin
         link(0, 1); link(0, 2); link(1, 2);
         if (scen == 1) begin
            link(8, 9); link(8, 10); link(9, 10);
         end
      end
   endtask

   // Reference: count neighbours, mark cores, then sweep label propagation pass by pass.
   logic [63:0] m_lab;
   logic [15:0] m_core;
   logic [3:0]  m_nc;
   logic [7:0]  m_it;

   task automatic model(input logic [17:0] e, input logic [3:0] m, input int drop);
      int L [N];
      bit c [N];
      int cnt, li, nl, it;
      bit ch, fin;
      for (int p = 0; p < N; p++) L[p] = 0;
      for (int i = 0; i < N; i++) begin
         cnt = 0;
         for (int j = 0; j < N; j++)
            if (i != j && dmat[i][j] < e && (i * N + j) != drop) cnt = (cnt < 15) ? cnt + 1 : 15;
         c[i] = (cnt >= int'(m));
      end
      nl = 1; it = 0; fin = 0;
      while (!fin) begin
         ch = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (i != j && c[i] && dmat[i][j] < e) begin
                  li = L[i];
                  if (li == 0) begin
                     li = nl; L[i] = nl; ch = 1;
                     if (nl < 15) nl++;
                  end
                  if (L[j] == 0 || L[j] > li) begin
                     L[j] = li; ch = 1;
                  end
               end
         it++;
`ifdef DBSCAN_EARLY_EXIT_EN
         fin = !ch || it == MAX_ITER;
`else
         fin = (it == MAX_ITER);
`endif
      end
      for (int p = 0; p < N; p++) begin
         m_lab[4*p +: 4] = L[p][3:0];
         m_core[p]       = c[p];
      end
      m_nc = 4'(nl - 1);
      m_it = 8'(it);
   endtask

   logic [63:0] got_lab;
   logic [15:0] got_core;
   logic [3:0]  got_nc;
   logic [7:0]  got_it;
   logic        got_err;
   int          got_cyc;
   bit          got_done;

   task automatic run(input logic [17:0] e, input logic [3:0] m, input int stall_at);
      int          stall_left;
      logic [IW-1:0] h_idx;
      logic [3:0]  h_lab;
      stall_left = 3;
      h_idx = '0; h_lab = '0;
      got_lab = '0; got_core = '0; got_cyc = 0; got_done = 0;
      got_nc = '0; got_it = '0; got_err = 1'b0;
      @(negedge clk);
      cfg_eps2 = e; cfg_minpts = m; start = 1'b1; bus.rd_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int guard = 0; guard < 20000 && !got_done; guard++) begin
         if (busy || done) got_cyc++;
         if (done) begin
            got_done = 1; got_nc = n_clusters; got_it = iter_cnt; got_err = err;
         end else begin
            if (bus.rd_valid && int'(bus.rd_idx) == stall_at && stall_left > 0) begin
               if (stall_left == 3) begin
                  h_idx = bus.rd_idx; h_lab = bus.rd_label;
               end else begin
                  check("stall_rd_idx", 64'(bus.rd_idx), 64'(h_idx));
                  check("stall_rd_label", 64'(bus.rd_label), 64'(h_lab));
               end
               stall_left--;
               bus.rd_ready = 1'b0;
            end else begin
               bus.rd_ready = 1'b1;
               if (bus.rd_valid) begin
                  got_lab[4*bus.rd_idx +: 4] = bus.rd_label;
                  got_core[bus.rd_idx]       = bus.rd_core;
               end
            end
            @(negedge clk);
         end
      end
      check("done_seen", 64'(got_done), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'({done, busy}), 64'd0);
   endtask

   typedef struct {
      int          scen;
      logic [17:0] e;
      logic [3:0]  m;
      int          drop;
      logic [63:0] lab;
      logic [15:0] cor;
      logic [3:0]  nc;
      logic [7:0]  it;
      logic        er;
   } vec_t;

   vec_t vt [4];

   initial begin
      int done_cnt;
      int rx, ry;
      int px [N];
      int py [N];
      logic [17:0] re;
      logic [3:0]  rm;

      vt[0] = '{0, 18'd300, 4'd2, -1, 64'h0000_0000_0000_0111, 16'h0007, 4'd1, EXP_IT, 1'b0};
      vt[1] = '{1, 18'd300, 4'd2, -1, 64'h0000_0222_0000_0111, 16'h0707, 4'd2, EXP_IT, 1'b0};
      vt[2] = '{2, 18'd300, 4'd1, -1, 64'h0000_0000_0001_1111, 16'h001F, 4'd1, EXP_IT, 1'b0};
      vt[3] = '{0, 18'd300, 4'd2, 5 * N + 7, 64'h0000_0000_0000_0111, 16'h0007, 4'd1, EXP_IT, 1'b1};

      bus.rd_ready = 1'b1;
      set_far();
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({busy, done, err, bus.pair_valid, bus.rd_valid}), 64'd0);
      check("reset_counters", 64'({n_clusters, iter_cnt, bus.rd_idx, bus.rd_label}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 64'(busy), 64'd0);

      for (int v = 0; v < 4; v++) begin
         setup_scen(vt[v].scen);
         drop_ord = vt[v].drop;
         model(vt[v].e, vt[v].m, vt[v].drop);
         run(vt[v].e, vt[v].m, -1);
         check($sformatf("v%0d_labels_model", v), got_lab, m_lab);
         check($sformatf("v%0d_labels_const", v), got_lab, vt[v].lab);
         check($sformatf("v%0d_core", v), 64'(got_core), 64'(vt[v].cor));
         check($sformatf("v%0d_core_model", v), 64'(got_core), 64'(m_core));
         check($sformatf("v%0d_n_clusters", v), 64'(got_nc), 64'(vt[v].nc));
         check($sformatf("v%0d_iter_cnt", v), 64'(got_it), 64'(vt[v].it));
         check($sformatf("v%0d_err", v), 64'(got_err), 64'(vt[v].er));
         check($sformatf("v%0d_cycles", v), 64'(got_cyc), 64'((N * N + DLAT) * (1 + int'(m_it)) + N + 1));
      end
      drop_ord = -1;

      // Reset during the first expand pass; err is still set from the dropped strobe.
      setup_scen(1);
      @(negedge clk);
      cfg_eps2 = 18'd300; cfg_minpts = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (N * N + DLAT + 40) @(negedge clk);
      check("expand_busy_before_rst", 64'({busy, n_clusters != 4'd0}), 64'd3);
      rst = 1'b1;
      #1;
      check("rst_busy_err", 64'({busy, err, done, bus.pair_valid, bus.rd_valid}), 64'd0);
      check("rst_counters", 64'({n_clusters, iter_cnt, bus.rd_label}), 64'd0);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b0;
         if (done) done_cnt++;
      end
      check("no_done_after_rst", 64'(done_cnt), 64'd0);
      check("idle_after_abort", 64'(busy), 64'd0);

      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < N; p++) begin
            px[p] = $urandom_range(0, 15);
            py[p] = $urandom_range(0, 15);
         end
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++) begin
               rx = px[a] - px[b];
               ry = py[a] - py[b];
               dmat[a][b] = 18'(rx * rx + ry * ry);
            end
         re = 18'($urandom_range(4, 40));
         rm = 4'($urandom_range(1, 4));
         model(re, rm, -1);
         run(re, rm, -1);
         check($sformatf("rnd%0d_labels", r), got_lab, m_lab);
         check($sformatf("rnd%0d_core", r), 64'(got_core), 64'(m_core));
         check($sformatf("rnd%0d_n_clusters", r), 64'(got_nc), 64'(m_nc));
         check($sformatf("rnd%0d_iter_cnt", r), 64'(got_it), 64'(m_it));
         check($sformatf("rnd%0d_err", r), 64'(got_err), 64'd0);
         check($sformatf("rnd%0d_cycles", r), 64'(got_cyc), 64'((N * N + DLAT) * (1 + int'(m_it)) + N + 1));
      end

      // Host holds rd_ready low for three cycles at entry 5.
      setup_scen(0);
      run(18'd300, 4'd2, 5);
      check("stall_labels", got_lab, 64'h0000_0000_0000_0111);
      check("stall_n_clusters", 64'(got_nc), 64'd1);
      check("stall_cycles", 64'(got_cyc), 64'((N * N + DLAT) * (1 + int'(EXP_IT)) + N + 1 + 3));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/dbscan_seq.md
DBSCAN_SEQ -- requirements
Module: dbscan_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 16, point count, power of two
- IW, 4, index width = log2(N)
- DLAT, 2, distance-pipe latency in cycles, >=1
- MAX_ITER, 6, maximum expand passes
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, reset: asynchronous, active-high
- start, in, 1, run request, sampled in IDLE only
- cfg_eps2, in, 18, squared radius, latched on start
- cfg_minpts, in, 4, core threshold, latched on start
- pair_valid, out, 1, pair issued this cycle
- pair_i, out, IW, centre index
- pair_j, out, IW, neighbour index
- dist_valid, in, 1, result strobe from distance pipe
- dist2, in, 18, squared distance of returned pair
- rd_valid, out, 1, readout entry valid
- rd_ready, in, 1, host accepts entry
- rd_idx, out, IW, readout point index
- rd_label, out, 4, cluster label, 0 = noise
- rd_core, out, 1, core flag
- n_clusters, out, 4, labels allocated
- iter_cnt, out, 8, expand passes executed
- busy, out, 1, high outside IDLE
- done, out, 1, one-cycle pulse at end of readout
- err, out, 1, sticky protocol error

Function
REQ-003 States IDLE, CORE, CDRAIN, EXPAND, EDRAIN, READ; all other encodings return to IDLE.
REQ-004 IDLE + start: latch cfg; clear all labels/core flags; next_label=1, iter_cnt=0, changed=0; go to CORE.
REQ-005 CORE/EXPAND issue one pair per cycle, i outer, j inner, (0,0) to (N-1,N-1), pair_valid=1; after (N-1,N-1) go to CDRAIN/EDRAIN.
REQ-006 Each issued (i,j) travels a DLAT-deep tag line; a result is consumed when the tag emerges; dist_valid must coincide with the emerging tag, otherwise err=1 (held until reset) and dist2 is ignored for that cycle.
REQ-007 Neighbour test: i!=j and dist2 < eps2 (strict, unsigned 18-bit).
REQ-008 CORE: per-i counter (4-bit, saturating at 15) increments on each neighbour; on result j=N-1, core[i]=1 iff count >= minpts, where count includes that last result; counter clears.
REQ-009 EXPAND, on a neighbour result with core[i]=1:
- Li := label[i]; if 0, Li = next_label, label[i] written, next_label++ (saturates at 15; further allocations reuse 15), changed=1.
- If label[j]==0 or label[j]>Li: label[j]=Li, changed=1.
- The Li allocated this cycle is used for j in the same cycle.
REQ-010 DRAIN states wait exactly DLAT cycles for outstanding results, then: CDRAIN goes to EXPAND; EDRAIN increments iter_cnt, clears changed, and goes to READ if the exit condition (REQ-016) holds, else to EXPAND.
REQ-011 READ: rd_idx starts at 0, rd_valid=1, entry fields stable until rd_valid&&rd_ready; index N-1 accepted -> done=1 for one cycle, go to IDLE.
REQ-012 n_clusters = next_label-1, updated live, held in IDLE until next start; start while busy is ignored.
REQ-013 Cycle count per run with an always-ready host: (N*N+DLAT)*(1+passes) + N + 1.

Reset
REQ-014 Reset mid-operation aborts immediately, with no done pulse:
- state IDLE
- all outputs 0 (n_clusters, iter_cnt, err included)
- labels 0, core flags 0, tag line cleared

Configuration
REQ-015 Macro DBSCAN_EARLY_EXIT_EN selects the exit condition.
REQ-016 With DBSCAN_EARLY_EXIT_EN: exit after a pass with changed=0 or iter_cnt==MAX_ITER. Without it: exit only when iter_cnt==MAX_ITER.

Structure
REQ-017 Package dbscan_pkg holds:
- IW, LABEL_W=4, DIST_W=18
- NOISE=0
- state enum
REQ-018 Sub-module dbscan_idx_pipe implements the DLAT-deep (valid,i,j) tag line.

Verification
REQ-019 Model the distance pipe as a DLAT-delayed lookup; check every run against a software reference model.
REQ-020 Points 0,1,2 mutual dist2=100, others 1000, eps2=300, minpts=2 -> labels 1,1,1, rest 0; n_clusters=1; cores 0-2.
REQ-021 Two disjoint triples {0,1,2},{8,9,10} -> labels 1 and 2; n_clusters=2; with DBSCAN_EARLY_EXIT_EN iter_cnt=2, without it 6.
REQ-022 Chain 0-1-2-3-4 (adjacent pairs only in range), minpts=1 -> all five labelled 1.
REQ-023 dist_valid dropped for one cycle during CORE -> err=1 and remains 1 through done.
REQ-024 rd_ready low for 3 cycles at rd_idx=5 -> rd_idx/rd_label held; rst asserted in EXPAND -> busy=0 and no done pulse.
